// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter letting two masters share one data_ram
// port, one transaction at a time, with a no-ack watchdog.
// Ports:
//   clk, rst          clock (rising) / async active-high reset
//   mN_cs_i/we_i      port N request (held until ack) and write enable
//   mN_addr_i/data_i  port N address / write data
//   mN_data_o         port N read data, updated on read ack, held after
//   mN_ack_o/err_o    port N one-cycle done pulse / watchdog expiry flag
//   mem_*_o           RAM cs/we/addr/wdata, valid only while busy
//   mem_data_i/ack_i  RAM read data / completion pulse
//   grant_cntN        completed port-N transactions, wrapping
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cs_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cs_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i,
  output logic [7:0]            grant_cnt0,
  output logic [7:0]            grant_cnt1
);

  // Watchdog counts BUSY cycles 0..TIMEOUT-1; the last one forces DONE.
  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_rr;
  logic                  r_gnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_m0_data;
  logic [DATA_WIDTH-1:0] r_m1_data;
  logic [WDW-1:0]        r_wdog;
  logic                  r_m0_ack;
  logic                  r_m1_ack;
  logic                  r_m0_err;
  logic                  r_m1_err;
  logic [7:0]            r_cnt0;
  logic [7:0]            r_cnt1;
  logic                  w_req;
  logic                  w_win;
  logic                  w_tmo;
  logic                  w_fin;

  assign w_req = m0_cs_i | m1_cs_i;
  // Sole requester wins; on a tie the round-robin pointer decides.
  assign w_win = (m0_cs_i & m1_cs_i) ? r_rr : m1_cs_i;
  assign w_tmo = (TIMEOUT != 0) && (r_wdog == WD_LAST);
  assign w_fin = mem_ack_i | w_tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    mem_cs_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) w_next = S_BUSY;
      end
      S_BUSY: begin
        mem_cs_o   = 1'b1;
        mem_we_o   = r_we;
        mem_addr_o = r_addr;
        mem_data_o = r_wdata;
        if (w_fin) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr      <= 1'b0;
      r_gnt     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wdog    <= '0;
      r_m0_data <= '0;
      r_m1_data <= '0;
      r_m0_ack  <= 1'b0;
      r_m1_ack  <= 1'b0;
      r_m0_err  <= 1'b0;
      r_m1_err  <= 1'b0;
      r_cnt0    <= '0;
      r_cnt1    <= '0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_gnt   <= w_win;
            r_we    <= w_win ? m1_we_i : m0_we_i;
            r_addr  <= w_win ? m1_addr_i : m0_addr_i;
            r_wdata <= w_win ? m1_data_i : m0_data_i;
            r_wdog  <= '0;
          end
        end
        S_BUSY: begin
          r_wdog <= r_wdog + WDW'(1);
          if (w_fin) begin
            // A real ack beats a same-cycle watchdog expiry.
            if (r_gnt) begin
              r_m1_ack <= 1'b1;
              r_m1_err <= ~mem_ack_i;
              if (mem_ack_i && !r_we) r_m1_data <= mem_data_i;
            end else begin
              r_m0_ack <= 1'b1;
              r_m0_err <= ~mem_ack_i;
              if (mem_ack_i && !r_we) r_m0_data <= mem_data_i;
            end
          end
        end
        S_DONE: begin
          if (r_gnt) r_cnt1 <= r_cnt1 + 8'd1;
          else       r_cnt0 <= r_cnt0 + 8'd1;
          r_rr <= ~r_gnt;
        end
        default: begin
          r_wdog <= '0;
        end
      endcase
    end
  end

  assign m0_data_o  = r_m0_data;
  assign m1_data_o  = r_m1_data;
  assign m0_ack_o   = r_m0_ack;
  assign m1_ack_o   = r_m1_ack;
  assign m0_err_o   = r_m0_err;
  assign m1_err_o   = r_m1_err;
  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter with a transaction-level
// reference model checked every cycle, plus directed literal checks.
module tb_mem_arbiter;

  localparam int TO = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic        clk;
  logic        rst;
  logic        cs [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] dout [2];
  logic        ack_o [2];
  logic        err_o [2];
  logic        mem_cs_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic [7:0]  cnt0, cnt1;

  req_t        rq [2][$];
  bit          hold [2];
  bit          eager, noise;
  logic [31:0] ram  [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  int          n_chk, n_fail;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cs_i(cs[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
    .m0_data_i(wd[0]), .m0_data_o(dout[0]),
    .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]),
    .m1_cs_i(cs[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
    .m1_data_i(wd[1]), .m1_data_o(dout[1]),
    .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .grant_cnt0(cnt0), .grant_cnt1(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // RAM latency in BUSY cycles, keyed on address; 0 = never acks.
  function automatic int ram_lat(input logic [31:0] a);
    if (a[15:12] == 4'hF) return 0;
    if (a[15:12] == 4'hE) return 16;
    return int'((a >> 2) & 32'd7) % 5 + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  task automatic push(input int p, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.we = w;
    r.addr = a;
    r.data = d;
    rq[p].push_back(r);
  endtask

  task automatic wait_ack(input int p, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (ack_o[p]) break;
    end
    chk("ack_seen", ack_o[p], 1);
  endtask

  task automatic drain(input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      @(negedge clk);
      if (rq[0].size() == 0 && rq[1].size() == 0 && !hold[0] && !hold[1])
        break;
    end
    chk("drain_done", i < lim, 1);
    repeat (3) @(negedge clk);
    chk("drain_idle", mem_cs_o, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Requesters: hold cs until ack, then drop or issue the next request.
  initial begin
    req_t r;
    for (int p = 0; p < 2; p++) begin
      cs[p] = 0; we[p] = 0; addr[p] = 0; wd[p] = 0; hold[p] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (rst) begin
          hold[p] = 0;
          cs[p] = 0;
        end else begin
          if (hold[p] && ack_o[p]) hold[p] = 0;
          if (!hold[p] && rq[p].size() > 0 &&
              (eager || $urandom_range(0, 3) != 0)) begin
            r = rq[p].pop_front();
            we[p] = r.we; addr[p] = r.addr; wd[p] = r.data;
            cs[p] = 1; hold[p] = 1;
          end
          if (!hold[p]) cs[p] = 0;
        end
      end
    end
  end

  // RAM: acks in the lat-th cycle of cs; junk data otherwise.
  initial begin
    int bn, lat;
    mem_ack_i = 0;
    mem_data_i = 0;
    bn = 0;
    ram[32'h8] = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      #1;
      mem_ack_i = 0;
      mem_data_i = $urandom;
      if (mem_cs_o) begin
        bn++;
        lat = ram_lat(mem_addr_o);
        if (lat != 0 && bn == lat) begin
          mem_ack_i = 1;
          if (mem_we_o) ram[mem_addr_o] = mem_data_o;
          else mem_data_i = ram.exists(mem_addr_o) ?
                            ram[mem_addr_o] : dflt(mem_addr_o);
        end
      end else begin
        bn = 0;
        if (noise && $urandom_range(0, 7) == 0) mem_ack_i = 1;
      end
    end
  end

  // Reference model: each grant yields a timeline of k busy cycles then
  // one ack cycle; compared against the DUT on every falling edge.
  initial begin
    int n, n0, k, w, rr, lat;
    bit act, t_err, e_cs, e_done;
    logic t_we;
    logic [31:0] t_addr, t_wd;
    logic [31:0] md [2];
    logic [7:0] mc [2];
    refm[32'h8] = 32'hDEADBEEF;
    n = 0; n0 = 0; k = 0; w = 0; rr = 0; act = 0; t_err = 0;
    t_we = 0; t_addr = 0; t_wd = 0;
    md[0] = 0; md[1] = 0; mc[0] = 0; mc[1] = 0;
    forever begin
      @(negedge clk);
      n++;
      if (rst) begin
        chk("rst_cs", mem_cs_o, 0);
        chk("rst_ack0", ack_o[0], 0);
        chk("rst_ack1", ack_o[1], 0);
        chk("rst_err0", err_o[0], 0);
        chk("rst_err1", err_o[1], 0);
        chk("rst_dout0", dout[0], 0);
        chk("rst_dout1", dout[1], 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        act = 0; rr = 0;
        md[0] = 0; md[1] = 0; mc[0] = 0; mc[1] = 0;
      end else begin
        e_cs = act && n > n0 && n <= n0 + k;
        e_done = act && n == n0 + k + 1;
        if (e_done && !t_err) begin
          if (t_we) refm[t_addr] = t_wd;
          else md[w] = refm.exists(t_addr) ? refm[t_addr] : dflt(t_addr);
        end
        chk("mem_cs", mem_cs_o, e_cs);
        if (e_cs) begin
          chk("mem_we", mem_we_o, t_we);
          chk("mem_addr", mem_addr_o, t_addr);
          chk("mem_wdata", mem_data_o, t_wd);
        end
        for (int p = 0; p < 2; p++) begin
          chk("ack", ack_o[p], e_done && w == p);
          chk("err", err_o[p], e_done && w == p && t_err);
          chk("dout", dout[p], md[p]);
        end
        chk("cnt0", cnt0, mc[0]);
        chk("cnt1", cnt1, mc[1]);
        if (e_done) begin
          act = 0;
          mc[w] = mc[w] + 8'd1;
          rr = 1 - w;
        end else if (!act && (cs[0] || cs[1])) begin
          w = (cs[0] && cs[1]) ? rr : (cs[1] ? 1 : 0);
          t_we = we[w]; t_addr = addr[w]; t_wd = wd[w];
          lat = ram_lat(t_addr);
          k = (lat == 0) ? TO : lat;
          t_err = (lat == 0);
          n0 = n;
          act = 1;
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int ord[$];
    int c, r;
    logic [31:0] a;
    rst = 1; eager = 1; noise = 0;
    n_chk = 0; n_fail = 0;
    repeat (3) @(posedge clk);
    #2 rst = 0;

    // single read
    push(0, 0, 32'h8, 32'h0);
    wait_ack(0, 50);
    chk("t1_data", dout[0], 32'hDEADBEEF);
    chk("t1_err", err_o[0], 0);
    chk("t1_ack1", ack_o[1], 0);
    @(negedge clk);
    chk("t1_cnt0", cnt0, 1);
    chk("t1_pulse", ack_o[0], 0);
    chk("t1_cnt1", cnt1, 0);

    // contention, both held
    do_reset();
    push(0, 0, 32'h100, 0); push(0, 0, 32'h104, 0);
    push(1, 0, 32'h200, 0); push(1, 0, 32'h204, 0);
    for (int i = 0; i < 300 && ord.size() < 4; i++) begin
      @(negedge clk);
      if (ack_o[0]) ord.push_back(0);
      if (ack_o[1]) ord.push_back(1);
    end
    chk("t2_n", ord.size(), 4);
    for (int i = 0; i < ord.size() && i < 4; i++)
      chk("t2_order", ord[i], i % 2);
    @(negedge clk);
    chk("t2_cnt0", cnt0, 2);
    chk("t2_cnt1", cnt1, 2);

    // write then readback
    do_reset();
    push(1, 1, 32'h14, 32'h12345678);
    wait_ack(1, 50);
    chk("t3_m1_data", dout[1], 0);
    push(0, 0, 32'h14, 0);
    wait_ack(0, 50);
    chk("t3_rd", dout[0], 32'h12345678);

    // watchdog expiry
    do_reset();
    push(0, 0, 32'hF000, 0);
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack_o[0]) break;
      if (mem_cs_o) c++;
    end
    chk("t4_cs_cycles", c, 16);
    chk("t4_ack", ack_o[0], 1);
    chk("t4_err", err_o[0], 1);
    chk("t4_cs_low", mem_cs_o, 0);
    chk("t4_data", dout[0], 0);
    // ack in the same cycle as expiry
    push(0, 0, 32'hE040, 0);
    wait_ack(0, 60);
    chk("t4b_err", err_o[0], 0);
    chk("t4b_data", dout[0], dflt(32'hE040));

    // reset mid-transaction
    @(negedge clk);
    chk("t5_pre_cnt0", cnt0, 2);
    push(0, 0, 32'hF000, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_cs_o) break;
    end
    chk("t5_busy", mem_cs_o, 1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("t5_cs_async", mem_cs_o, 0);
    chk("t5_cnt0", cnt0, 0);
    chk("t5_ack", ack_o[0], 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    push(0, 0, 32'h8, 0);
    wait_ack(0, 50);
    chk("t5_data", dout[0], 32'hDEADBEEF);
    @(negedge clk);
    chk("t5_cnt0_after", cnt0, 1);

    // counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) push(0, 0, 32'h0, 0);
    drain(3000);
    chk("t6_cnt0", cnt0, 0);
    chk("t6_cnt1", cnt1, 0);

    // random traffic
    do_reset();
    eager = 0;
    noise = 1;
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        r = $urandom_range(0, 15);
        if (r == 0) a = 32'hF000;
        else if (r == 1) a = 32'hE000 | (32'($urandom_range(0, 15)) << 2);
        else a = 32'($urandom_range(0, 31)) << 2;
        push(p, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end
    drain(40000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
